// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM state type and the output post-processing
// helper for the convolution accumulator/writer.
//   DEF_DATA_W / DEF_FRAC_W / DEF_ACC_W : default data, fraction and accumulator widths
//   state_e                             : writer FSM states
//   sat_relu()                          : saturate to a DATA_W signed value, optional ReLU
package conv_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_ACC_W  = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Largest / smallest representable result, held at accumulator width so the
  // comparison in sat_relu stays signed and full precision.
  localparam logic signed [DEF_ACC_W-1:0] SAT_MAX =
    DEF_ACC_W'((64'sd1 <<< (DEF_DATA_W - 1)) - 64'sd1);
  localparam logic signed [DEF_ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp an already-shifted accumulator value into the result range, then
  // optionally force negative results to zero.
  function automatic logic [DEF_DATA_W-1:0] sat_relu(
    input logic signed [DEF_ACC_W-1:0] v,
    input logic                        relu_en
  );
    logic signed [DEF_ACC_W-1:0] c;
    if (v > SAT_MAX) begin
      c = SAT_MAX;
    end else if (v < SAT_MIN) begin
      c = SAT_MIN;
    end else begin
      c = v;
    end
    if (relu_en && c[DEF_ACC_W-1]) begin
      c = {DEF_ACC_W{1'b0}};
    end else begin
      c = c;
    end
    return c[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: product register and window accumulator.
//   clk, rstn        : clock, synchronous active-low reset
//   clr              : drop product, accumulator and pipeline valids (new pass)
//   in_vld/in_first/in_last : tap qualifiers aligned with a/b (cycle T+1)
//   a, b             : signed operands (feature, weight)
//   acc_next         : value the accumulator takes at the end of T+2
//   out_vld/out_last : qualifiers of the tap currently in the product register
module mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    in_vld,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [DATA_W-1:0]       a,
  input  logic [DATA_W-1:0]       b,
  output logic signed [ACC_W-1:0] acc_next,
  output logic                    out_vld,
  output logic                    out_last
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [2*DATA_W-1:0] prod_r;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [ACC_W-1:0]    acc_next_s;
  logic                       vld_r;
  logic                       first_r;
  logic                       last_r;

  // Signed multiply, sign-extend product and pick load-vs-accumulate.
  always_comb begin
    prod_s     = $signed(a) * $signed(b);
    prod_ext_s = {{(ACC_W-2*DATA_W){prod_r[2*DATA_W-1]}}, prod_r};
    if (first_r) begin
      acc_next_s = prod_ext_s;
    end else begin
      acc_next_s = acc_r + prod_ext_s;
    end
  end

  // Product and accumulator registers; gaps (in_vld=0) hold the product.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      prod_r  <= {(2*DATA_W){1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      vld_r   <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      vld_r <= in_vld;
      if (in_vld) begin
        prod_r  <= prod_s;
        first_r <= in_first;
        last_r  <= in_last;
      end else begin
        prod_r  <= prod_r;
        first_r <= first_r;
        last_r  <= last_r;
      end
      if (vld_r) begin
        acc_r <= acc_next_s;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign acc_next = acc_next_s;
  assign out_vld  = vld_r;
  assign out_last = last_r;

endmodule

// File: rtl/conv_acc_writer.sv
// conv_acc_writer: accumulates convolution taps from the address iterator,
// adds bias, rounds down to Q8.8 with saturation/ReLU and writes results to
// the output SRAM at sequential addresses.
//   clk, rstn            : clock, synchronous active-low reset
//   go                   : start (or restart) a layer pass
//   cena, first_data, last_data : tap strobe/qualifiers in address cycle T
//   q_data, q_weight, q_bias    : SRAM read data, valid in T+1
//   wr_en, wr_addr, wr_data     : output SRAM write port (valid in T+3)
//   done                 : one-cycle pulse after the final address is written
module conv_acc_writer
  import conv_pkg::*;
#(
  parameter int OUTPUT_BATCH = 5,
  parameter int OUT_W        = 24,
  parameter int OUT_H        = 24,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int ACC_W        = DEF_ACC_W,
  parameter bit RELU_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  input  logic              cena,
  input  logic              first_data,
  input  logic              last_data,
  input  logic [DATA_W-1:0] q_data,
  input  logic [DATA_W-1:0] q_weight,
  input  logic [DATA_W-1:0] q_bias,
  output logic              wr_en,
  output logic [11:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done
);

  localparam logic [11:0] ADDR_LAST = 12'(OUTPUT_BATCH * OUT_W * OUT_H - 1);

  state_e                  state_r;
  logic                    vld_d_r;
  logic                    first_d_r;
  logic                    last_d_r;
  logic [DATA_W-1:0]       bias_r;
  logic [11:0]             addr_cnt_r;
  logic                    wr_en_r;
  logic [11:0]             wr_addr_r;
  logic [DATA_W-1:0]       wr_data_r;
  logic                    done_r;
  logic signed [ACC_W-1:0] acc_next_s;
  logic                    tap_vld_s;
  logic                    tap_last_s;
  logic signed [ACC_W-1:0] bias_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shr_s;
  logic [DATA_W-1:0]       result_s;
  logic                    wr_fire_s;

  // Align tap qualifiers with the SRAM data; taps outside RUN are dropped here.
  always_ff @(posedge clk) begin
    if (!rstn || go) begin
      vld_d_r   <= 1'b0;
      first_d_r <= 1'b0;
      last_d_r  <= 1'b0;
      bias_r    <= {DATA_W{1'b0}};
    end else begin
      vld_d_r   <= !cena && (state_r == ST_RUN);
      first_d_r <= first_data;
      last_d_r  <= last_data;
      if (vld_d_r && last_d_r) begin
        bias_r <= q_bias;
      end else begin
        bias_r <= bias_r;
      end
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (go),
    .in_vld   (vld_d_r),
    .in_first (first_d_r),
    .in_last  (last_d_r),
    .a        (q_data),
    .b        (q_weight),
    .acc_next (acc_next_s),
    .out_vld  (tap_vld_s),
    .out_last (tap_last_s)
  );

  // Bias add in the accumulator's fixed-point scale, truncate, saturate.
  always_comb begin
    bias_ext_s = {{(ACC_W-DATA_W){bias_r[DATA_W-1]}}, bias_r} <<< FRAC_W;
    sum_s      = acc_next_s + bias_ext_s;
    shr_s      = sum_s >>> FRAC_W;
    result_s   = sat_relu(shr_s, RELU_EN);
    if ((state_r == ST_RUN) && tap_vld_s && tap_last_s) begin
      wr_fire_s = 1'b1;
    end else begin
      wr_fire_s = 1'b0;
    end
  end

  // Pass FSM, address counter and registered write port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      done_r     <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= 12'd0;
      wr_data_r  <= {DATA_W{1'b0}};
      addr_cnt_r <= 12'd0;
    end else if (go) begin
      state_r    <= ST_RUN;
      done_r     <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= 12'd0;
      wr_data_r  <= {DATA_W{1'b0}};
      addr_cnt_r <= 12'd0;
    end else begin
      wr_en_r <= wr_fire_s;
      if (wr_fire_s) begin
        wr_addr_r  <= addr_cnt_r;
        wr_data_r  <= result_s;
        addr_cnt_r <= (addr_cnt_r == ADDR_LAST) ? 12'd0 : addr_cnt_r + 12'd1;
      end else begin
        wr_addr_r  <= wr_addr_r;
        wr_data_r  <= wr_data_r;
        addr_cnt_r <= addr_cnt_r;
      end
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        ST_RUN: begin
          // The final-address write is visible this cycle; done follows it.
          if (wr_en_r && (wr_addr_r == ADDR_LAST)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign done    = done_r;

endmodule
